// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry layout, lookup response and entry-ready helper.
package rob_pkg;

    localparam int ROB_ENTRIES = 8;
    localparam int ROB_DATA_W  = 32;
    localparam int ROB_REG_W   = 5;
    localparam int ROB_PC_W    = 32;
    localparam int ROB_ID_W    = $clog2(ROB_ENTRIES);

    typedef struct packed {
        logic                  valid;
        logic                  rf_wen;
        logic [ROB_REG_W-1:0]  rf_dest;
        logic [ROB_DATA_W-1:0] rf_data;
        logic                  xcpt;
        logic [ROB_PC_W-1:0]   pc;
    } rob_entry_t;

    typedef struct packed {
        logic                  hit;
        logic [ROB_DATA_W-1:0] data;
    } rob_lookup_t;

    function automatic logic entry_ready(input rob_entry_t e);
        return e.valid & e.rf_wen & ~e.xcpt;
    endfunction

endpackage

// File: rtl/rob_lookup_port.sv
// One ALU source lookup: selects a ready ROB entry by id, optionally overridden by a WB bypass.
module rob_lookup_port
    import rob_pkg::*;
#(
    parameter int NUM_ENTRIES = ROB_ENTRIES,
    parameter int DATA_W      = ROB_DATA_W,
    localparam int ID_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] ready,
    input  logic [DATA_W-1:0]      data [NUM_ENTRIES],
    input  logic                   byp_valid,
    input  logic [ID_W-1:0]        byp_id,
    input  logic [DATA_W-1:0]      byp_data,
    input  logic [ID_W-1:0]        id,
    output rob_lookup_t            rsp
);

    always_comb begin
        rsp.hit  = ready[id];
        rsp.data = ready[id] ? data[id] : '0;
        if (byp_valid && (byp_id == id)) begin
            rsp.hit  = 1'b1;
            rsp.data = byp_data;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with precise exceptions and two source lookup ports.
// Define ROB_WB_BYPASS_EN to forward a same-cycle WB result to the lookup ports.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int NUM_ENTRIES = ROB_ENTRIES,
    parameter int DATA_W      = ROB_DATA_W,
    parameter int REG_W       = ROB_REG_W,
    parameter int PC_W        = ROB_PC_W,
    localparam int ID_W       = $clog2(NUM_ENTRIES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              rob_full,
    output logic [ID_W-1:0]   rob_tail,
    input  logic              wb_valid,
    input  logic [ID_W-1:0]   wb_instr_id,
    input  logic              wb_rf_wen,
    input  logic [REG_W-1:0]  wb_rf_dest,
    input  logic [DATA_W-1:0] wb_rf_data,
    input  logic              wb_xcpt,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic [ID_W-1:0]   rob_src1_id,
    output logic              rob_src1_hit,
    output logic [DATA_W-1:0] rob_src1_data,
    input  logic [ID_W-1:0]   rob_src2_id,
    output logic              rob_src2_hit,
    output logic [DATA_W-1:0] rob_src2_data,
    output logic              rf_wen,
    output logic [REG_W-1:0]  rf_dest,
    output logic [DATA_W-1:0] rf_data,
    output logic              xcpt_valid,
    output logic [PC_W-1:0]   xcpt_pc,
    output logic              flush_rob
);

    logic [NUM_ENTRIES-1:0] vld_q;
    logic                   wen_q  [NUM_ENTRIES];
    logic [REG_W-1:0]       dest_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
    logic                   xcpt_q [NUM_ENTRIES];
    logic [PC_W-1:0]        pc_q   [NUM_ENTRIES];

    logic [ID_W-1:0]        tail_q;
    logic [ID_W:0]          count_q;
    logic                   full_q;

    rob_entry_t             ent [NUM_ENTRIES];
    rob_entry_t             tail_ent;
    logic [NUM_ENTRIES-1:0] ready;
    logic                   retire, xret, alloc_ok, wb_ok, byp_valid;
    logic [ID_W-1:0]        wb_off;
    logic [ID_W:0]          count_n;
    rob_lookup_t            lk1, lk2;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent[i]   = '{valid: vld_q[i], rf_wen: wen_q[i], rf_dest: dest_q[i],
                         rf_data: data_q[i], xcpt: xcpt_q[i], pc: pc_q[i]};
            ready[i] = entry_ready(ent[i]);
        end
        tail_ent = ent[tail_q];
        retire   = tail_ent.valid;
        xret     = retire & tail_ent.xcpt;
        // A full buffer still accepts an alloc when the tail frees a slot on the same edge.
        alloc_ok = alloc_valid & (~full_q | retire) & ~xret;
        wb_off   = wb_instr_id - tail_q;
        wb_ok    = wb_valid & ~vld_q[wb_instr_id] & ({1'b0, wb_off} < count_q) & ~xret;
        count_n  = count_q + {{ID_W{1'b0}}, alloc_ok} - {{ID_W{1'b0}}, retire};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q      <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            rf_wen     <= 1'b0;
            rf_dest    <= '0;
            rf_data    <= '0;
            xcpt_valid <= 1'b0;
            xcpt_pc    <= '0;
            flush_rob  <= 1'b0;
        end else begin
            rf_wen     <= retire & tail_ent.rf_wen & ~tail_ent.xcpt;
            xcpt_valid <= xret;
            flush_rob  <= xret;
            if (retire && !xret) begin
                rf_dest <= tail_ent.rf_dest;
                rf_data <= tail_ent.rf_data;
            end
            if (xret) begin
                xcpt_pc <= tail_ent.pc;
                vld_q   <= '0;
                tail_q  <= '0;
                count_q <= '0;
                full_q  <= 1'b0;
            end else begin
                if (retire) begin
                    vld_q[tail_q] <= 1'b0;
                    tail_q        <= tail_q + 1'b1;
                end
                if (wb_ok) vld_q[wb_instr_id] <= 1'b1;
                count_q <= count_n;
                full_q  <= (count_n == (ID_W+1)'(NUM_ENTRIES));
            end
        end
    end

    // Entry payload carries no reset; vld_q alone decides whether it is meaningful.
    always_ff @(posedge clock) begin
        if (wb_ok) begin
            wen_q[wb_instr_id]  <= wb_rf_wen;
            dest_q[wb_instr_id] <= wb_rf_dest;
            data_q[wb_instr_id] <= wb_rf_data;
            xcpt_q[wb_instr_id] <= wb_xcpt;
            pc_q[wb_instr_id]   <= wb_pc;
        end
    end

`ifdef ROB_WB_BYPASS_EN
    assign byp_valid = wb_valid & wb_rf_wen & ~wb_xcpt;
`else
    assign byp_valid = 1'b0;
`endif

    rob_lookup_port #(.NUM_ENTRIES(NUM_ENTRIES), .DATA_W(DATA_W)) u_lookup1 (
        .ready(ready), .data(data_q), .byp_valid(byp_valid), .byp_id(wb_instr_id),
        .byp_data(wb_rf_data), .id(rob_src1_id), .rsp(lk1)
    );

    rob_lookup_port #(.NUM_ENTRIES(NUM_ENTRIES), .DATA_W(DATA_W)) u_lookup2 (
        .ready(ready), .data(data_q), .byp_valid(byp_valid), .byp_id(wb_instr_id),
        .byp_data(wb_rf_data), .id(rob_src2_id), .rsp(lk2)
    );

    assign rob_src1_hit  = lk1.hit;
    assign rob_src1_data = lk1.data;
    assign rob_src2_hit  = lk2.hit;
    assign rob_src2_data = lk2.data;
    assign rob_full      = full_q;
    assign rob_tail      = tail_q;

    a_alloc_full: assert property (@(posedge clock) disable iff (reset)
        !(alloc_valid && full_q && !retire))
        else $error("reorder_buffer: alloc while full");
    a_wb_legal: assert property (@(posedge clock) disable iff (reset)
        !(wb_valid && !xret && !wb_ok))
        else $error("reorder_buffer: WB to valid or out-of-window entry");

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: retire order, full/wrap, exceptions, lookups, reset.
module tb_reorder_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic        rob_full;
    logic [2:0]  rob_tail;
    logic        wb_valid;
    logic [2:0]  wb_instr_id;
    logic        wb_rf_wen;
    logic [4:0]  wb_rf_dest;
    logic [31:0] wb_rf_data;
    logic        wb_xcpt;
    logic [31:0] wb_pc;
    logic [2:0]  rob_src1_id, rob_src2_id;
    logic        rob_src1_hit, rob_src2_hit;
    logic [31:0] rob_src1_data, rob_src2_data;
    logic        rf_wen;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data;
    logic        xcpt_valid;
    logic [31:0] xcpt_pc;
    logic        flush_rob;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    reorder_buffer dut (
        .clock(clock), .reset(reset), .alloc_valid(alloc_valid), .rob_full(rob_full),
        .rob_tail(rob_tail), .wb_valid(wb_valid), .wb_instr_id(wb_instr_id),
        .wb_rf_wen(wb_rf_wen), .wb_rf_dest(wb_rf_dest), .wb_rf_data(wb_rf_data),
        .wb_xcpt(wb_xcpt), .wb_pc(wb_pc), .rob_src1_id(rob_src1_id),
        .rob_src1_hit(rob_src1_hit), .rob_src1_data(rob_src1_data),
        .rob_src2_id(rob_src2_id), .rob_src2_hit(rob_src2_hit),
        .rob_src2_data(rob_src2_data), .rf_wen(rf_wen), .rf_dest(rf_dest),
        .rf_data(rf_data), .xcpt_valid(xcpt_valid), .xcpt_pc(xcpt_pc), .flush_rob(flush_rob)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_wb(input logic [2:0] id, input logic [4:0] dest, input logic [31:0] data,
                         input logic x = 1'b0, input logic [31:0] pc = 32'h0);
        wb_valid    = 1'b1;
        wb_instr_id = id;
        wb_rf_wen   = 1'b1;
        wb_rf_dest  = dest;
        wb_rf_data  = data;
        wb_xcpt     = x;
        wb_pc       = pc;
    endtask

    task automatic chk_rf(input string tag, input logic [4:0] dest, input logic [31:0] data,
                          input logic [2:0] tail);
        chk({tag, "_wen"}, 64'(rf_wen), 64'd1);
        chk({tag, "_dest"}, 64'(rf_dest), 64'(dest));
        chk({tag, "_data"}, 64'(rf_data), 64'(data));
        chk({tag, "_tail"}, 64'(rob_tail), 64'(tail));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; alloc_valid = 1'b0; wb_valid = 1'b0; wb_instr_id = '0;
        wb_rf_wen = 1'b0; wb_rf_dest = '0; wb_rf_data = '0; wb_xcpt = 1'b0; wb_pc = '0;
        rob_src1_id = '0; rob_src2_id = '0;
        tick(); tick();
        chk("rst_tail", 64'(rob_tail), 64'd0);
        chk("rst_full", 64'(rob_full), 64'd0);
        chk("rst_rfwen", 64'(rf_wen), 64'd0);
        chk("rst_xcpt", 64'(xcpt_valid), 64'd0);
        chk("rst_flush", 64'(flush_rob), 64'd0);
        chk("rst_hit1", 64'(rob_src1_hit), 64'd0);
        reset = 1'b0;

        // in-order retire of three results
        alloc_valid = 1'b1;
        tick(); tick(); tick();
        alloc_valid = 1'b0;
        do_wb(3'd0, 5'd1, 32'hA);
        tick();
        do_wb(3'd1, 5'd2, 32'hB);
        rob_src1_id = 3'd0;
        #1;
        chk("t2_hit0", 64'(rob_src1_hit), 64'd1);
        chk("t2_data0", 64'(rob_src1_data), 64'hA);
        tick();
        chk_rf("t2_r1", 5'd1, 32'hA, 3'd1);
        do_wb(3'd2, 5'd3, 32'hC);
        tick();
        chk_rf("t2_r2", 5'd2, 32'hB, 3'd2);
        wb_valid = 1'b0;
        tick();
        chk_rf("t2_r3", 5'd3, 32'hC, 3'd3);
        tick();
        chk("t2_idle_wen", 64'(rf_wen), 64'd0);

        // out-of-order WB: younger first, retire waits for the tail
        alloc_valid = 1'b1;
        tick(); tick();
        alloc_valid = 1'b0;
        do_wb(3'd4, 5'd4, 32'h44);
        tick();
        wb_valid = 1'b0;
        rob_src1_id = 3'd4;
        #1;
        chk("t3_hit4", 64'(rob_src1_hit), 64'd1);
        chk("t3_data4", 64'(rob_src1_data), 64'h44);
        tick();
        chk("t3_wait_wen", 64'(rf_wen), 64'd0);
        chk("t3_wait_tail", 64'(rob_tail), 64'd3);
        tick();
        chk("t3_wait2_wen", 64'(rf_wen), 64'd0);
        do_wb(3'd3, 5'd3, 32'h33);
        tick();
        wb_valid = 1'b0;
        tick();
        chk_rf("t3_r3", 5'd3, 32'h33, 3'd4);
        tick();
        chk_rf("t3_r4", 5'd4, 32'h44, 3'd5);
        tick();
        chk("t3_idle_wen", 64'(rf_wen), 64'd0);
        #1;
        chk("t3_hit4_gone", 64'(rob_src1_hit), 64'd0);

        // precise exception at the tail
        alloc_valid = 1'b1;
        tick(); tick();
        alloc_valid = 1'b0;
        do_wb(3'd5, 5'd7, 32'h77, 1'b1, 32'h40);
        tick();
        do_wb(3'd6, 5'd8, 32'h66);
        alloc_valid = 1'b1;
        rob_src1_id = 3'd5;
        #1;
        chk("t5_xcpt_nohit", 64'(rob_src1_hit), 64'd0);
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b0;
        chk("t5_xcpt_valid", 64'(xcpt_valid), 64'd1);
        chk("t5_flush", 64'(flush_rob), 64'd1);
        chk("t5_xcpt_pc", 64'(xcpt_pc), 64'h40);
        chk("t5_no_wen", 64'(rf_wen), 64'd0);
        chk("t5_tail", 64'(rob_tail), 64'd0);
        tick();
        chk("t5_xcpt_pulse", 64'(xcpt_valid), 64'd0);
        chk("t5_flush_pulse", 64'(flush_rob), 64'd0);
        chk("t5_after_wen", 64'(rf_wen), 64'd0);
        rob_src1_id = 3'd6;
        #1;
        chk("t5_id6_dropped", 64'(rob_src1_hit), 64'd0);

        // fill, alloc-with-retire while full, tail wrap
        alloc_valid = 1'b1;
        repeat (7) tick();
        chk("t4_full7", 64'(rob_full), 64'd0);
        tick();
        chk("t4_full8", 64'(rob_full), 64'd1);
        alloc_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k >= 2)
                chk_rf($sformatf("t4_ret%0d", k - 2), 5'(k - 1), 32'h100 + 32'(k - 2), 3'((k - 1) % 8));
            if (k == 2) chk("t4_full_kept", 64'(rob_full), 64'd1);
            if (k == 3) chk("t4_full_drop", 64'(rob_full), 64'd0);
            if (k <= 7) do_wb(3'(k), 5'(k + 1), 32'h100 + 32'(k));
            else wb_valid = 1'b0;
            alloc_valid = (k == 1);
            tick();
        end
        chk("t4_after_wen", 64'(rf_wen), 64'd0);

        // lookup of an entry being written this cycle
        alloc_valid = 1'b1;
        tick(); tick();
        alloc_valid = 1'b0;
        do_wb(3'd2, 5'd9, 32'h55);
        rob_src1_id = 3'd2;
        rob_src2_id = 3'd2;
        #1;
`ifdef ROB_WB_BYPASS_EN
        chk("t6_byp_hit1", 64'(rob_src1_hit), 64'd1);
        chk("t6_byp_data1", 64'(rob_src1_data), 64'h55);
        chk("t6_byp_hit2", 64'(rob_src2_hit), 64'd1);
`else
        chk("t6_nobyp_hit1", 64'(rob_src1_hit), 64'd0);
        chk("t6_nobyp_data1", 64'(rob_src1_data), 64'd0);
        chk("t6_nobyp_hit2", 64'(rob_src2_hit), 64'd0);
`endif
        tick();
        wb_valid = 1'b0;
        #1;
        chk("t6_reg_hit1", 64'(rob_src1_hit), 64'd1);
        chk("t6_reg_data1", 64'(rob_src1_data), 64'h55);
        chk("t6_reg_hit2", 64'(rob_src2_hit), 64'd1);
        chk("t6_reg_data2", 64'(rob_src2_data), 64'h55);
        chk("t6_no_retire", 64'(rf_wen), 64'd0);
        chk("t6_tail", 64'(rob_tail), 64'd0);

        // reset with five entries valid
        alloc_valid = 1'b1;
        tick(); tick(); tick();
        alloc_valid = 1'b0;
        do_wb(3'd1, 5'd1, 32'h11); tick();
        do_wb(3'd3, 5'd3, 32'h13); tick();
        do_wb(3'd4, 5'd4, 32'h14); tick();
        do_wb(3'd5, 5'd5, 32'h15); tick();
        wb_valid = 1'b0;
        rob_src1_id = 3'd3;
        rob_src2_id = 3'd1;
        #1;
        chk("t1_pre_hit", 64'(rob_src1_hit), 64'd1);
        reset = 1'b1;
        tick();
        chk("t1_tail", 64'(rob_tail), 64'd0);
        chk("t1_full", 64'(rob_full), 64'd0);
        chk("t1_hit1", 64'(rob_src1_hit), 64'd0);
        chk("t1_hit2", 64'(rob_src2_hit), 64'd0);
        chk("t1_wen", 64'(rf_wen), 64'd0);
        reset = 1'b0;
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        do_wb(3'd0, 5'd5, 32'h99);
        tick();
        wb_valid = 1'b0;
        tick();
        chk_rf("t1_post", 5'd5, 32'h99, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
